// File: rtl/diag_severity_stack_pkg.sv
// Shared types for the diagnostic severity stack: severity encoding, command opcodes
// and the default-sized severity table.
package diag_pkg;

    localparam int unsigned DEF_NUM_CODES = 8;

    typedef enum logic [1:0] {
        SEV_IGNORE = 2'd0,
        SEV_WARN   = 2'd1,
        SEV_ERROR  = 2'd2,
        SEV_FATAL  = 2'd3
    } sev_e;

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_PUSH     = 3'd1,
        OP_POP      = 3'd2,
        OP_SET      = 3'd3,
        OP_SET_MASK = 3'd4
    } diag_op_e;

    typedef sev_e table_t [DEF_NUM_CODES];

endpackage

// File: rtl/diag_severity_stack_sat_counter.sv
// Width-parametrised up-counter that sticks at all-ones; synchronous active-low reset.
module diag_sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/diag_severity_stack.sv
// Runtime severity table with a push/pop snapshot stack; classifies events, reports
// registered severity, counts warnings/errors and latches fatal (which freezes commands).
module diag_severity_stack
    import diag_pkg::*;
#(
    parameter int unsigned NUM_CODES   = 8,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned CNT_W       = 8,
    localparam int unsigned CW = $clog2(NUM_CODES),
    localparam int unsigned LW = $clog2(STACK_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [CW-1:0]       cmd_code,
    input  logic [NUM_CODES-1:0] cmd_mask,
    input  logic [1:0]          cmd_sev,
    input  logic                evt_valid,
    input  logic [CW-1:0]       evt_code,
    input  logic signed [31:0]  evt_val,
    output logic                rpt_valid,
    output logic [CW-1:0]       rpt_code,
    output logic [1:0]          rpt_sev,
    output logic [CNT_W-1:0]    warn_cnt,
    output logic [CNT_W-1:0]    err_cnt,
    output logic                fatal_flag,
    output logic [LW-1:0]       stack_level,
    output logic                overflow,
    output logic                underflow
);

    typedef sev_e tbl_t [NUM_CODES];

    tbl_t          tbl_q, tbl_d;
    tbl_t          stk_q [STACK_DEPTH];
    tbl_t          stk_d [STACK_DEPTH];
    logic [LW-1:0] lvl_q, lvl_d;
    logic          ovf_q, ovf_d, unf_q, unf_d, fatal_q, fatal_d;
    logic          rpt_valid_q, rpt_valid_d;
    logic [CW-1:0] rpt_code_q, rpt_code_d;
    sev_e          rpt_sev_q, rpt_sev_d;
    sev_e          evt_sev;
    logic          evt_raised;

    assign cmd_ready = ~fatal_q;

    // Events see the table as it was before this edge's command, so lookup uses tbl_q.
    always_comb begin
        evt_sev = SEV_IGNORE;
        for (int unsigned i = 0; i < NUM_CODES; i++) begin
            if (evt_code == CW'(i)) evt_sev = tbl_q[i];
        end
        evt_raised = evt_valid && (evt_val > 32'sd0) &&
                     ({1'b0, evt_code} < (CW+1)'(NUM_CODES));
    end

    always_comb begin
        tbl_d = tbl_q;
        stk_d = stk_q;
        lvl_d = lvl_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (cmd_valid && cmd_ready) begin
            case (diag_op_e'(cmd_op))
                OP_PUSH: begin
                    if (lvl_q == LW'(STACK_DEPTH)) begin
                        ovf_d = 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                            if (lvl_q == LW'(i)) stk_d[i] = tbl_q;
                        end
                        lvl_d = lvl_q + LW'(1);
                    end
                end
                OP_POP: begin
                    if (lvl_q == '0) begin
                        unf_d = 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                            if (lvl_q == LW'(i + 1)) tbl_d = stk_q[i];
                        end
                        lvl_d = lvl_q - LW'(1);
                    end
                end
                OP_SET: begin
                    for (int unsigned i = 0; i < NUM_CODES; i++) begin
                        if (cmd_code == CW'(i)) tbl_d[i] = sev_e'(cmd_sev);
                    end
                end
                OP_SET_MASK: begin
                    for (int unsigned i = 0; i < NUM_CODES; i++) begin
                        if (cmd_mask[i]) tbl_d[i] = sev_e'(cmd_sev);
                    end
                end
                default: ;
            endcase
        end

        rpt_valid_d = evt_raised && (evt_sev != SEV_IGNORE);
        rpt_code_d  = rpt_code_q;
        rpt_sev_d   = rpt_sev_q;
        if (rpt_valid_d) begin
            rpt_code_d = evt_code;
            rpt_sev_d  = evt_sev;
        end
        fatal_d = fatal_q | (evt_raised && (evt_sev == SEV_FATAL));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tbl_q       <= '{default: SEV_WARN};
            lvl_q       <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            fatal_q     <= 1'b0;
            rpt_valid_q <= 1'b0;
            rpt_code_q  <= '0;
            rpt_sev_q   <= SEV_IGNORE;
        end else begin
            tbl_q       <= tbl_d;
            lvl_q       <= lvl_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            fatal_q     <= fatal_d;
            rpt_valid_q <= rpt_valid_d;
            rpt_code_q  <= rpt_code_d;
            rpt_sev_q   <= rpt_sev_d;
        end
    end

    // Snapshots are only readable below stack_level, so they need no reset.
    always_ff @(posedge clk) begin
        stk_q <= stk_d;
    end

    diag_sat_counter #(.WIDTH(CNT_W)) u_warn_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (evt_raised && (evt_sev == SEV_WARN)),
        .count_o (warn_cnt)
    );

    diag_sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (evt_raised && (evt_sev == SEV_ERROR)),
        .count_o (err_cnt)
    );

    assign rpt_valid   = rpt_valid_q;
    assign rpt_code    = rpt_code_q;
    assign rpt_sev     = rpt_sev_q;
    assign fatal_flag  = fatal_q;
    assign stack_level = lvl_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: tb/tb_diag_severity_stack.sv
// Directed bench for diag_severity_stack: stimulus queues expected reports, a negedge
// monitor pops and compares them; status outputs are checked inline.
module tb_diag_severity_stack;

    localparam int unsigned NC = 8;
    localparam int unsigned SD = 4;
    localparam int unsigned CW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = '0;
    logic [2:0]        cmd_code = '0;
    logic [7:0]        cmd_mask = '0;
    logic [1:0]        cmd_sev = '0;
    logic              evt_valid = 1'b0;
    logic [2:0]        evt_code = '0;
    logic signed [31:0] evt_val = '0;
    logic              rpt_valid;
    logic [2:0]        rpt_code;
    logic [1:0]        rpt_sev;
    logic [CW-1:0]     warn_cnt, err_cnt;
    logic              fatal_flag;
    logic [2:0]        stack_level;
    logic              overflow, underflow;

    typedef struct packed { logic [2:0] code; logic [1:0] sev; } rpt_t;
    rpt_t exp_q[$];

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] PUSH = 3'd1, POP = 3'd2, SET = 3'd3, SETM = 3'd4;
    localparam logic [1:0] IGN = 2'd0, WRN = 2'd1, ERR = 2'd2, FTL = 2'd3;

    diag_severity_stack #(.NUM_CODES(NC), .STACK_DEPTH(SD), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_code(cmd_code), .cmd_mask(cmd_mask), .cmd_sev(cmd_sev),
        .evt_valid(evt_valid), .evt_code(evt_code), .evt_val(evt_val),
        .rpt_valid(rpt_valid), .rpt_code(rpt_code), .rpt_sev(rpt_sev),
        .warn_cnt(warn_cnt), .err_cnt(err_cnt), .fatal_flag(fatal_flag),
        .stack_level(stack_level), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rpt_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rpt_unexpected: got code=%0d sev=%0d, required no report", rpt_code, rpt_sev);
            end else begin
                rpt_t e;
                e = exp_q.pop_front();
                if (rpt_code !== e.code || rpt_sev !== e.sev) begin
                    bad++;
                    $display("FAIL rpt_match: got code=%0d sev=%0d, required code=%0d sev=%0d",
                             rpt_code, rpt_sev, e.code, e.sev);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic cv, input logic [2:0] op, input logic [2:0] code,
                        input logic [7:0] mask, input logic [1:0] sev,
                        input logic ev, input logic [2:0] ecode, input int eval,
                        input logic exp_v, input logic [1:0] exp_sev);
        rpt_t e;
        cmd_valid = cv; cmd_op = op; cmd_code = code; cmd_mask = mask; cmd_sev = sev;
        evt_valid = ev; evt_code = ecode; evt_val = eval;
        if (exp_v) begin
            e.code = ecode;
            e.sev  = exp_sev;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        evt_valid = 1'b0;
    endtask

    task automatic cmd(input logic [2:0] op, input logic [2:0] code, input logic [7:0] mask,
                       input logic [1:0] sev);
        step(1'b1, op, code, mask, sev, 1'b0, 3'd0, 0, 1'b0, IGN);
    endtask

    task automatic evt(input logic [2:0] code, input int val, input logic exp_v,
                       input logic [1:0] exp_sev);
        step(1'b0, 3'd0, 3'd0, 8'h00, IGN, 1'b1, code, val, exp_v, exp_sev);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_level", 32'(stack_level), 0);
        chk("rst_warn", 32'(warn_cnt), 0);
        chk("rst_err", 32'(err_cnt), 0);
        chk("rst_fatal", 32'(fatal_flag), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_unf", 32'(underflow), 0);
        chk("rst_rpt_valid", 32'(rpt_valid), 0);
    endtask

    initial begin
        do_reset();

        // Basic WARN report with one-cycle latency.
        evt(3'd2, 5, 1'b1, WRN);
        chk("warn_first", 32'(warn_cnt), 1);

        // IGNORE code and non-positive values produce nothing.
        cmd(SET, 3'd3, 8'h00, IGN);
        evt(3'd3, 7, 1'b0, IGN);
        evt(3'd2, 0, 1'b0, IGN);
        evt(3'd2, -4, 1'b0, IGN);
        chk("warn_after_ignored", 32'(warn_cnt), 1);
        chk("err_after_ignored", 32'(err_cnt), 0);

        // Push, override all to ERROR, pop restores.
        cmd(PUSH, 3'd0, 8'h00, IGN);
        chk("level_push1", 32'(stack_level), 1);
        cmd(SETM, 3'd0, 8'hFF, ERR);
        evt(3'd1, 1, 1'b1, ERR);
        chk("err_masked", 32'(err_cnt), 1);
        cmd(POP, 3'd0, 8'h00, IGN);
        chk("level_pop0", 32'(stack_level), 0);
        evt(3'd1, 1, 1'b1, WRN);
        evt(3'd3, 1, 1'b0, IGN);
        chk("warn_after_pop", 32'(warn_cnt), 2);

        // Fill the stack past its depth, then drain past empty.
        cmd(SET, 3'd5, 8'h00, ERR);
        cmd(PUSH, 3'd0, 8'h00, IGN);
        cmd(SET, 3'd5, 8'h00, IGN);
        cmd(PUSH, 3'd0, 8'h00, IGN);
        cmd(SET, 3'd6, 8'h00, ERR);
        cmd(PUSH, 3'd0, 8'h00, IGN);
        cmd(PUSH, 3'd0, 8'h00, IGN);
        chk("ovf_before_full", 32'(overflow), 0);
        cmd(PUSH, 3'd0, 8'h00, IGN);
        chk("level_full", 32'(stack_level), 4);
        chk("ovf_set", 32'(overflow), 1);
        cmd(SETM, 3'd0, 8'hFF, IGN);
        evt(3'd0, 1, 1'b0, IGN);
        cmd(POP, 3'd0, 8'h00, IGN);
        evt(3'd6, 1, 1'b1, ERR);
        repeat (3) cmd(POP, 3'd0, 8'h00, IGN);
        chk("unf_before_empty", 32'(underflow), 0);
        cmd(POP, 3'd0, 8'h00, IGN);
        chk("level_empty", 32'(stack_level), 0);
        chk("unf_set", 32'(underflow), 1);
        evt(3'd5, 1, 1'b1, ERR);
        evt(3'd6, 1, 1'b1, WRN);
        evt(3'd3, 1, 1'b0, IGN);
        chk("err_after_drain", 32'(err_cnt), 3);
        idle(1);

        // Mid-operation reset clears table, stack and sticky flags.
        cmd(PUSH, 3'd0, 8'h00, IGN);
        do_reset();
        evt(3'd3, 1, 1'b1, WRN);
        chk("warn_after_reset", 32'(warn_cnt), 1);

        // 2-bit counter saturates at 3.
        repeat (5) evt(3'd2, 9, 1'b1, WRN);
        chk("warn_saturated", 32'(warn_cnt), 3);

        // Command and event on the same edge: event sees the old severity.
        step(1'b1, SET, 3'd4, 8'h00, ERR, 1'b1, 3'd4, 2, 1'b1, WRN);
        evt(3'd4, 2, 1'b1, ERR);
        chk("err_after_same_cycle", 32'(err_cnt), 1);

        // Reserved opcode is a no-op.
        cmd(3'd5, 3'd0, 8'hFF, IGN);
        chk("reserved_level", 32'(stack_level), 0);
        evt(3'd1, 1, 1'b1, WRN);

        // Fatal freezes commands, events keep reporting.
        cmd(SET, 3'd0, 8'h00, FTL);
        chk("ready_before_fatal", 32'(cmd_ready), 1);
        evt(3'd0, 1, 1'b1, FTL);
        chk("fatal_set", 32'(fatal_flag), 1);
        chk("ready_after_fatal", 32'(cmd_ready), 0);
        cmd(SET, 3'd0, 8'h00, WRN);
        cmd(PUSH, 3'd0, 8'h00, IGN);
        chk("level_frozen", 32'(stack_level), 0);
        evt(3'd0, 3, 1'b1, FTL);
        evt(3'd4, 3, 1'b1, ERR);
        chk("err_after_fatal", 32'(err_cnt), 2);
        evt(3'd2, 3, 1'b1, WRN);
        chk("fatal_sticky", 32'(fatal_flag), 1);

        idle(3);
        chk("pending_reports", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
